// File: rtl/int_check.sv
`default_nettype none
// ============================================================================
// Module      : int_check
// Description : Streaming lexical checker for C-style integer declarations of
//               the form "int id {, id} ;". One ASCII character is consumed
//               per clock; out pulses for one cycle after the ';' that closes
//               a well-formed statement.
// Ports       : clk   - system clock, rising-edge active
//               reset - asynchronous, active-low reset
//               in    - ASCII character, sampled on every rising edge
//               out   - registered one-cycle acceptance flag
// Revision    : 1.0 - initial release
// ============================================================================
module int_check (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic       out
);

    localparam logic [7:0] c_chr_space = 8'h20;
    localparam logic [7:0] c_chr_tab   = 8'h09;
    localparam logic [7:0] c_chr_comma = 8'h2C;
    localparam logic [7:0] c_chr_semi  = 8'h3B;
    localparam logic [7:0] c_chr_us    = 8'h5F;
    localparam logic [7:0] c_chr_i     = 8'h69;
    localparam logic [7:0] c_chr_n     = 8'h6E;
    localparam logic [7:0] c_chr_t     = 8'h74;

    typedef enum logic [3:0] {
        S_START = 4'd0,   // between statements, skipping leading WS
        S_T_I   = 4'd1,   // keyword "i" seen
        S_T_N   = 4'd2,   // keyword "in" seen
        S_T_T   = 4'd3,   // keyword "int" seen, WS required next
        S_SEP   = 4'd4,   // expecting an identifier
        S_K_I   = 4'd5,   // identifier "i" so far
        S_K_N   = 4'd6,   // identifier "in" so far
        S_K_INT = 4'd7,   // identifier "int" so far (reserved unless extended)
        S_ID    = 4'd8,   // inside a legal identifier
        S_POST  = 4'd9,   // WS after an identifier
        S_ERR   = 4'd10   // syntax error, waiting for ';'
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_accept;

    logic w_ws;
    logic w_let;
    logic w_dig;
    logic w_us;
    logic w_comma;
    logic w_semi;
    logic w_idch;     // legal identifier continuation character
    logic w_idstart;  // legal identifier first character

    assign w_ws      = (in == c_chr_space) || (in == c_chr_tab);
    assign w_let     = ((in >= 8'h41) && (in <= 8'h5A)) || ((in >= 8'h61) && (in <= 8'h7A));
    assign w_dig     = (in >= 8'h30) && (in <= 8'h39);
    assign w_us      = (in == c_chr_us);
    assign w_comma   = (in == c_chr_comma);
    assign w_semi    = (in == c_chr_semi);
    assign w_idch    = w_let || w_dig || w_us;
    assign w_idstart = w_let || w_us;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_START;
            out     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            out     <= w_accept;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_START: begin
                if (w_semi)               w_next_state = S_START;
                else if (w_ws)            w_next_state = S_START;
                else if (in == c_chr_i)   w_next_state = S_T_I;
                else                      w_next_state = S_ERR;
            end
            S_T_I: begin
                if (in == c_chr_n)        w_next_state = S_T_N;
                else if (w_semi)          w_next_state = S_START;
                else                      w_next_state = S_ERR;
            end
            S_T_N: begin
                if (in == c_chr_t)        w_next_state = S_T_T;
                else if (w_semi)          w_next_state = S_START;
                else                      w_next_state = S_ERR;
            end
            S_T_T: begin
                if (w_ws)                 w_next_state = S_SEP;
                else if (w_semi)          w_next_state = S_START;
                else                      w_next_state = S_ERR;
            end
            S_SEP: begin
                if (w_ws)                 w_next_state = S_SEP;
                else if (in == c_chr_i)   w_next_state = S_K_I;
                else if (w_idstart)       w_next_state = S_ID;
                else if (w_semi)          w_next_state = S_START;
                else                      w_next_state = S_ERR;
            end
            S_K_I, S_K_N: begin
                // "i" and "in" are complete identifiers in their own right;
                // only the exact word "int" is rejected.
                if ((r_state == S_K_I) && (in == c_chr_n))      w_next_state = S_K_N;
                else if ((r_state == S_K_N) && (in == c_chr_t)) w_next_state = S_K_INT;
                else if (w_idch)          w_next_state = S_ID;
                else if (w_ws)            w_next_state = S_POST;
                else if (w_comma)         w_next_state = S_SEP;
                else if (w_semi) begin
                    w_next_state = S_START;
                    w_accept     = 1'b1;
                end else                  w_next_state = S_ERR;
            end
            S_K_INT: begin
                if (w_idch)               w_next_state = S_ID;
                else if (w_semi)          w_next_state = S_START;
                else                      w_next_state = S_ERR;
            end
            S_ID: begin
                if (w_idch)               w_next_state = S_ID;
                else if (w_ws)            w_next_state = S_POST;
                else if (w_comma)         w_next_state = S_SEP;
                else if (w_semi) begin
                    w_next_state = S_START;
                    w_accept     = 1'b1;
                end else                  w_next_state = S_ERR;
            end
            S_POST: begin
                if (w_ws)                 w_next_state = S_POST;
                else if (w_comma)         w_next_state = S_SEP;
                else if (w_semi) begin
                    w_next_state = S_START;
                    w_accept     = 1'b1;
                end else                  w_next_state = S_ERR;
            end
            S_ERR: begin
                if (w_semi)               w_next_state = S_START;
                else                      w_next_state = S_ERR;
            end
            default: begin
                w_next_state = S_START;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_int_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_check
// Description : Scoreboard bench for int_check. The stimulus process drives
//               one character per cycle and queues the out value expected
//               after that character is sampled; a monitor pops and compares
//               one entry per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_check;

    logic       clk;
    logic       reset;
    logic [7:0] in;
    logic       out;

    int n_pass;
    int n_total;

    bit r_expq[$];

    int_check u_dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: out=%b expected=%b at %0t", name, act, exp, $time);
    endtask

    // Monitor: out reflects the character sampled on this edge.
    initial begin
        bit e;
        forever begin
            @(posedge clk);
            #1;
            if (r_expq.size() > 0) begin
                e = r_expq.pop_front();
                check("stream", out, e);
            end
        end
    end

    // Drive a statement; only its final ';' may raise out, and only if ok.
    task automatic send_str(input string s, input bit ok);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            in = s[i];
            r_expq.push_back((i == s.len() - 1) ? ok : 1'b0);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        in      = 8'h20;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", out, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        send_str("int i,nt, A;", 1'b1);
        send_str(";", 1'b0);
        send_str("int b_1,c;", 1'b1);
        send_str("int i,in,intd;", 1'b1);
        send_str("int f,int,g;", 1'b0);
        send_str(" int q;", 1'b1);
        send_str("int e[2];", 1'b0);
        send_str("int A;", 1'b1);
        send_str("int a b;", 1'b0);
        send_str("int a,;", 1'b0);
        send_str("int;", 1'b0);
        send_str("intx;", 1'b0);
        send_str("int 1a;", 1'b0);
        send_str("  int\tx ,  y ;", 1'b1);
        send_str("int in;", 1'b1);
        send_str("int int;", 1'b0);
        send_str("Int a;", 1'b0);
        send_str("int a;", 1'b1);

        // Reset mid-statement discards the partial "int abc".
        send_str("int abc", 1'b0);
        @(negedge clk);
        in    = 8'h20;
        reset = 1'b0;
        #1;
        check("reset_mid", out, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        send_str("c;", 1'b0);

        // Asynchronous reset clears out while it is high.
        send_str("int z;", 1'b1);
        @(posedge clk);
        #2;
        check("out_high_before_reset", out, 1'b1);
        in    = 8'h20;
        reset = 1'b0;
        #1;
        check("async_reset", out, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        send_str("int w;", 1'b1);

        for (int k = 0; k < 20 && r_expq.size() > 0; k++) @(posedge clk);
        #2;
        n_total++;
        if (r_expq.size() == 0) n_pass++;
        else $display("FAIL drain: pending=%0d expected=0", r_expq.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
